// File: rtl/mem_prefetch_arbiter.sv
// mem_prefetch_arbiter
//   Two-port val/rdy arbiter in front of a single prefetch buffer. Only one
//   buffer transaction may be outstanding at a time. The response is routed
//   back to the port that owns the transaction. That owner is latched at
//   grant time; the opaque field of the message plays no part in routing.
//
//   Optional feature: define MEM_PREFETCH_ARB_PERF_EN to add the saturating
//   per-port grant counters grant_cnt0 and grant_cnt1.
//
//   state | meaning
//   IDLE  | nothing outstanding; the arbitration winner sees reqN_rdy=1
//   ISSUE | latched request held on buf_req_* until the buffer takes it
//   WAIT  | buffer response forwarded to the latched owner port only
module mem_prefetch_arbiter #(
    parameter int p_opaque_nbits = 8,
    parameter int req_nbits      = 77,
    parameter int resp_nbits     = 45
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_val,
    output logic                  req0_rdy,
    input  logic [req_nbits-1:0]  req0_msg,
    input  logic                  req0_domain,

    input  logic                  req1_val,
    output logic                  req1_rdy,
    input  logic [req_nbits-1:0]  req1_msg,
    input  logic                  req1_domain,

    output logic                  buf_req_val,
    input  logic                  buf_req_rdy,
    output logic [req_nbits-1:0]  buf_req_msg,
    output logic                  buf_domain,

    input  logic                  buf_resp_val,
    output logic                  buf_resp_rdy,
    input  logic [resp_nbits-1:0] buf_resp_msg,

    output logic                  resp0_val,
    input  logic                  resp0_rdy,
    output logic [resp_nbits-1:0] resp0_msg,

    output logic                  resp1_val,
    input  logic                  resp1_rdy,
    output logic [resp_nbits-1:0] resp1_msg
`ifdef MEM_PREFETCH_ARB_PERF_EN
    ,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1
`endif
);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_issue = 2'd1;
    localparam logic [1:0] st_wait  = 2'd2;

    localparam int body_nbits = req_nbits - p_opaque_nbits;

    logic [1:0]                state_q;
    logic                      rr_q;
    logic                      owner_q;
    logic                      domain_q;
    logic [p_opaque_nbits-1:0] opaque_q;
    logic [body_nbits-1:0]     body_q;

    logic                      win;
    logic                      any_val;
    logic                      grant;
    logic                      in_idle;
    logic                      in_issue;
    logic                      in_wait;
    logic                      owner_rdy;
    logic                      resp_hs;
    logic [req_nbits-1:0]      win_msg;
    logic                      win_domain;

    // Arbitration: a lone valid port wins outright; a tie goes to the port
    // named by rr. With nothing valid, the rr port is offered rdy.
    always_comb begin
        any_val = req0_val | req1_val;
        if (req0_val && req1_val) begin
            win = rr_q;
        end else if (req1_val) begin
            win = 1'b1;
        end else if (req0_val) begin
            win = 1'b0;
        end else begin
            win = rr_q;
        end
        win_msg    = win ? req1_msg    : req0_msg;
        win_domain = win ? req1_domain : req0_domain;
    end

    // Handshake outputs are decoded from the state. They are all held low
    // while reset is asserted, whatever state the register still holds.
    always_comb begin
        in_idle   = (state_q == st_idle)  && !reset;
        in_issue  = (state_q == st_issue) && !reset;
        in_wait   = (state_q == st_wait)  && !reset;
        grant     = in_idle && any_val;
        owner_rdy = owner_q ? resp1_rdy : resp0_rdy;

        req0_rdy     = in_idle && !win;
        req1_rdy     = in_idle &&  win;

        buf_req_val  = in_issue;
        buf_req_msg  = {opaque_q, body_q};
        buf_domain   = (in_issue || in_wait) ? domain_q : 1'b0;

        buf_resp_rdy = in_wait && owner_rdy;
        resp0_val    = in_wait && !owner_q && buf_resp_val;
        resp1_val    = in_wait &&  owner_q && buf_resp_val;
        resp0_msg    = buf_resp_msg;
        resp1_msg    = buf_resp_msg;

        resp_hs      = buf_resp_val && buf_resp_rdy;
    end

    // Transaction sequencing, plus latching of the granted request context.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= st_idle;
            rr_q     <= 1'b0;
            owner_q  <= 1'b0;
            domain_q <= 1'b0;
            opaque_q <= '0;
            body_q   <= '0;
        end else begin
            case (state_q)
                st_idle: begin
                    if (grant) begin
                        opaque_q <= win_msg[req_nbits-1 -: p_opaque_nbits];
                        body_q   <= win_msg[body_nbits-1:0];
                        domain_q <= win_domain;
                        owner_q  <= win;
                        rr_q     <= ~win;
                        state_q  <= st_issue;
                    end
                end
                st_issue: begin
                    if (buf_req_rdy) begin
                        state_q <= st_wait;
                    end
                end
                st_wait: begin
                    if (resp_hs) begin
                        state_q <= st_idle;
                    end
                end
                default: begin
                    state_q <= st_idle;
                end
            endcase
        end
    end

`ifdef MEM_PREFETCH_ARB_PERF_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    // Per-port grant counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else if (grant) begin
            if (!win && (cnt0_q != 16'hffff)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (win && (cnt1_q != 16'hffff)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mem_prefetch_arbiter.sv
// Testbench for mem_prefetch_arbiter: directed scenarios, then randomized
// traffic, all compared against a transaction-level reference model.
module tb_mem_prefetch_arbiter;

    localparam int req_nbits  = 77;
    localparam int resp_nbits = 45;

    logic                  clk;
    logic                  reset;
    logic                  req0_val, req0_rdy, req0_domain;
    logic                  req1_val, req1_rdy, req1_domain;
    logic [req_nbits-1:0]  req0_msg, req1_msg;
    logic                  buf_req_val, buf_req_rdy, buf_domain;
    logic [req_nbits-1:0]  buf_req_msg;
    logic                  buf_resp_val, buf_resp_rdy;
    logic [resp_nbits-1:0] buf_resp_msg;
    logic                  resp0_val, resp0_rdy;
    logic                  resp1_val, resp1_rdy;
    logic [resp_nbits-1:0] resp0_msg, resp1_msg;
`ifdef MEM_PREFETCH_ARB_PERF_EN
    logic [15:0]           grant_cnt0, grant_cnt1;
`endif

    mem_prefetch_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req0_msg     (req0_msg),
        .req0_domain  (req0_domain),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .req1_msg     (req1_msg),
        .req1_domain  (req1_domain),
        .buf_req_val  (buf_req_val),
        .buf_req_rdy  (buf_req_rdy),
        .buf_req_msg  (buf_req_msg),
        .buf_domain   (buf_domain),
        .buf_resp_val (buf_resp_val),
        .buf_resp_rdy (buf_resp_rdy),
        .buf_resp_msg (buf_resp_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp0_msg    (resp0_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .resp1_msg    (resp1_msg)
`ifdef MEM_PREFETCH_ARB_PERF_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass;
    int n_total;

    // Reference model: one outstanding-transaction record plus the tie-break
    // pointer; the grant history is kept for the ordering scenario.
    bit                   m_busy;
    bit                   m_issued;
    bit                   m_owner;
    bit                   m_dom;
    bit                   m_rr;
    logic [req_nbits-1:0] m_msg;
    int                   m_cnt [2];
    bit                   grant_log [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick();
        if (req0_val && req1_val) return m_rr;
        return req1_val;
    endfunction

    function automatic logic [req_nbits-1:0] rnd_req();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[req_nbits-1:0];
    endfunction

    function automatic logic [resp_nbits-1:0] rnd_resp();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[resp_nbits-1:0];
    endfunction

    // Compare every DUT output against what the model says it must be now.
    task automatic settle_check();
        bit w;
        bit e_bv, e_v0, e_v1, e_brr;
        #1;
        e_bv = 0; e_v0 = 0; e_v1 = 0; e_brr = 0;
        if (reset) begin
            chk("rst_req0_rdy", {127'd0, req0_rdy}, 128'd0);
            chk("rst_req1_rdy", {127'd0, req1_rdy}, 128'd0);
        end else if (!m_busy) begin
            if (req0_val || req1_val) begin
                w = pick();
                chk("idle_req0_rdy", {127'd0, req0_rdy}, {127'd0, !w});
                chk("idle_req1_rdy", {127'd0, req1_rdy}, {127'd0, w});
            end
            chk("idle_buf_domain", {127'd0, buf_domain}, 128'd0);
        end else begin
            chk("busy_req0_rdy", {127'd0, req0_rdy}, 128'd0);
            chk("busy_req1_rdy", {127'd0, req1_rdy}, 128'd0);
            chk("busy_buf_domain", {127'd0, buf_domain}, {127'd0, m_dom});
            if (!m_issued) begin
                e_bv = 1;
                chk("issue_buf_req_msg", {51'd0, buf_req_msg}, {51'd0, m_msg});
            end else begin
                e_v0  = !m_owner && buf_resp_val;
                e_v1  =  m_owner && buf_resp_val;
                e_brr = m_owner ? resp1_rdy : resp0_rdy;
            end
        end
        chk("buf_req_val", {127'd0, buf_req_val}, {127'd0, e_bv});
        chk("buf_resp_rdy", {127'd0, buf_resp_rdy}, {127'd0, e_brr});
        chk("resp0_val", {127'd0, resp0_val}, {127'd0, e_v0});
        chk("resp1_val", {127'd0, resp1_val}, {127'd0, e_v1});
        chk("resp0_msg", {83'd0, resp0_msg}, {83'd0, buf_resp_msg});
        chk("resp1_msg", {83'd0, resp1_msg}, {83'd0, buf_resp_msg});
`ifdef MEM_PREFETCH_ARB_PERF_EN
        chk("grant_cnt0", {112'd0, grant_cnt0}, 128'(m_cnt[0]));
        chk("grant_cnt1", {112'd0, grant_cnt1}, 128'(m_cnt[1]));
`endif
    endtask

    // Apply this cycle's handshakes to the model, then move to the next cycle.
    task automatic advance();
        bit w;
        if (reset) begin
            m_busy   = 0;
            m_issued = 0;
            m_rr     = 0;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end else if (!m_busy) begin
            if (req0_val || req1_val) begin
                w        = pick();
                m_busy   = 1;
                m_issued = 0;
                m_owner  = w;
                m_msg    = w ? req1_msg : req0_msg;
                m_dom    = w ? req1_domain : req0_domain;
                m_rr     = !w;
                grant_log.push_back(w);
                if (m_cnt[w] < 65535) m_cnt[w]++;
            end
        end else if (!m_issued) begin
            if (buf_req_rdy) m_issued = 1;
        end else if (buf_resp_val && (m_owner ? resp1_rdy : resp0_rdy)) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle_check();
        advance();
    endtask

    task automatic drive_idle();
        req0_val     = 0; req1_val    = 0;
        req0_msg     = '0; req1_msg   = '0;
        req0_domain  = 0; req1_domain = 0;
        buf_req_rdy  = 0;
        buf_resp_val = 0; buf_resp_msg = '0;
        resp0_rdy    = 0; resp1_rdy   = 0;
    endtask

    initial begin
        logic [req_nbits-1:0]  m0;
        logic [req_nbits-1:0]  m1;
        logic [resp_nbits-1:0] r0;
        int bound;

        n_pass  = 0;
        n_total = 0;
        m_busy  = 0; m_issued = 0; m_rr = 0; m_owner = 0; m_dom = 0; m_msg = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;

        drive_idle();
        reset = 1;
        cyc();
        cyc();
        reset = 0;

        // Single secure request from port 0, answered two cycles after issue.
        m0 = {8'h5a, 3'd1, 32'h0000_1000, 2'd2, 32'h0000_0000};
        req0_val = 1; req0_domain = 1; req0_msg = m0;
        settle_check();
        chk("r032_req0_rdy", {127'd0, req0_rdy}, 128'd1);
        chk("r032_no_early_issue", {127'd0, buf_req_val}, 128'd0);
        advance();
        req0_val = 0; buf_req_rdy = 1;
        settle_check();
        chk("r032_buf_req_val", {127'd0, buf_req_val}, 128'd1);
        chk("r032_buf_domain", {127'd0, buf_domain}, 128'd1);
        chk("r032_buf_req_msg", {51'd0, buf_req_msg}, {51'd0, m0});
        advance();
        buf_req_rdy = 0; resp0_rdy = 1;
        cyc();
        r0 = {8'h5a, 3'd1, 2'd2, 32'hcafe_f00d};
        buf_resp_val = 1; buf_resp_msg = r0;
        settle_check();
        chk("r032_resp0_val", {127'd0, resp0_val}, 128'd1);
        chk("r032_resp0_msg", {83'd0, resp0_msg}, {83'd0, r0});
        chk("r032_resp1_val", {127'd0, resp1_val}, 128'd0);
        advance();
        drive_idle();
        settle_check();
        chk("r032_back_idle_domain", {127'd0, buf_domain}, 128'd0);
        advance();

        // Both ports valid from reset: grants must alternate starting at 0.
        reset = 1;
        cyc();
        reset = 0;
        grant_log.delete();
        req0_val = 1; req1_val = 1;
        req0_msg = rnd_req(); req1_msg = rnd_req();
        req0_domain = 0; req1_domain = 1;
        buf_req_rdy = 1; buf_resp_val = 1; buf_resp_msg = rnd_resp();
        resp0_rdy = 1; resp1_rdy = 1;
        bound = 0;
        while (!(grant_log.size() >= 4 && !m_busy) && bound < 40) begin
            cyc();
            bound++;
        end
        chk("r033_grant_count", 128'(grant_log.size()), 128'd4);
        if (grant_log.size() >= 4) begin
            chk("r033_grant0", {127'd0, grant_log[0]}, 128'd0);
            chk("r033_grant1", {127'd0, grant_log[1]}, 128'd1);
            chk("r033_grant2", {127'd0, grant_log[2]}, 128'd0);
            chk("r033_grant3", {127'd0, grant_log[3]}, 128'd1);
        end
        drive_idle();
        cyc();

        // Buffer stalls the issued request for five cycles.
        m1 = rnd_req();
        req1_val = 1; req1_domain = 1; req1_msg = m1;
        cyc();
        req0_val = 1; req0_msg = rnd_req(); buf_req_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            settle_check();
            chk("r034_buf_req_val", {127'd0, buf_req_val}, 128'd1);
            chk("r034_buf_req_msg", {51'd0, buf_req_msg}, {51'd0, m1});
            chk("r034_buf_domain", {127'd0, buf_domain}, 128'd1);
            chk("r034_req0_rdy", {127'd0, req0_rdy}, 128'd0);
            chk("r034_req1_rdy", {127'd0, req1_rdy}, 128'd0);
            advance();
        end
        req0_val = 0; req1_val = 0; buf_req_rdy = 1;
        cyc();

        // Owner 1 holds off the response for three cycles.
        buf_req_rdy = 0; buf_resp_val = 1; buf_resp_msg = rnd_resp();
        resp0_rdy = 1; resp1_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("r035_buf_resp_rdy", {127'd0, buf_resp_rdy}, 128'd0);
            chk("r035_resp1_val", {127'd0, resp1_val}, 128'd1);
            chk("r035_resp0_val", {127'd0, resp0_val}, 128'd0);
            advance();
        end
        resp1_rdy = 1;
        settle_check();
        chk("r035_complete_rdy", {127'd0, buf_resp_rdy}, 128'd1);
        advance();

        // Stray response while idle is neither accepted nor forwarded.
        drive_idle();
        buf_resp_val = 1; buf_resp_msg = rnd_resp(); resp0_rdy = 1; resp1_rdy = 1;
        for (int i = 0; i < 2; i++) begin
            settle_check();
            chk("r036_buf_resp_rdy", {127'd0, buf_resp_rdy}, 128'd0);
            chk("r036_resp0_val", {127'd0, resp0_val}, 128'd0);
            chk("r036_resp1_val", {127'd0, resp1_val}, 128'd0);
            advance();
        end

        // Reset lands while waiting for the response.
        drive_idle();
        req0_val = 1; req0_msg = rnd_req();
        cyc();
        req0_val = 0; buf_req_rdy = 1;
        cyc();
        buf_req_rdy = 0; buf_resp_val = 1; buf_resp_msg = rnd_resp(); resp0_rdy = 0;
        cyc();
        reset = 1;
        cyc();
        reset = 0; resp0_rdy = 1; resp1_rdy = 1;
        req0_val = 1; req1_val = 1; req0_msg = rnd_req(); req1_msg = rnd_req();
        settle_check();
        chk("r037_resp0_val", {127'd0, resp0_val}, 128'd0);
        chk("r037_resp1_val", {127'd0, resp1_val}, 128'd0);
        chk("r037_buf_resp_rdy", {127'd0, buf_resp_rdy}, 128'd0);
        chk("r037_rr_req0_rdy", {127'd0, req0_rdy}, 128'd1);
        chk("r037_rr_req1_rdy", {127'd0, req1_rdy}, 128'd0);
`ifdef MEM_PREFETCH_ARB_PERF_EN
        chk("r037_grant_cnt0", {112'd0, grant_cnt0}, 128'd0);
        chk("r037_grant_cnt1", {112'd0, grant_cnt1}, 128'd0);
`endif
        advance();

        // Randomized traffic, including stray responses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            req0_val     = ($urandom_range(0, 1) == 1);
            req1_val     = ($urandom_range(0, 1) == 1);
            req0_msg     = rnd_req();
            req1_msg     = rnd_req();
            req0_domain  = ($urandom_range(0, 1) == 1);
            req1_domain  = ($urandom_range(0, 1) == 1);
            buf_req_rdy  = ($urandom_range(0, 9) < 7);
            buf_resp_val = ($urandom_range(0, 9) < 6);
            buf_resp_msg = rnd_resp();
            resp0_rdy    = ($urandom_range(0, 9) < 7);
            resp1_rdy    = ($urandom_range(0, 9) < 7);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
